// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam logic [1:0] RF_WE_WRITE = 2'b01;
    localparam logic [1:0] RF_WE_IDLE  = 2'b00;
    localparam logic [4:0] REG_ZERO    = 5'd0;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Grant counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester-side write-back bus plus the register-file write port driven by the arbiter.
interface rf_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [1:0]             rf_wE;
    logic [ADDR_W-1:0]      rf_rW;
    logic [DATA_W-1:0]      rf_busW;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, rf_wE, rf_rW, rf_busW
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, rf_wE, rf_rW, rf_busW
    );
endinterface

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] winner
);
    int   idx;
    logic found;

    // Scan from the pointer position and keep only the first hit.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter with burst lock feeding the register-file write port.
// Optional per-requester grant counters are built when RF_WB_PERF_EN is defined.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    rf_wb_arbiter_if.slave   bus,
    input  logic [2:0]       perf_sel,
    output logic [15:0]      perf_cnt
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_r, state_s;
    logic [PTR_W-1:0]  ptr_r, ptr_s, owner_r, owner_s, win_s, arb_win_s;
    logic [NREQ-1:0]   arb_grant_s, ready_s;
    logic              accept_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;
    logic [1:0]        rf_we_r;
    logic [ADDR_W-1:0] rf_rw_r;
    logic [DATA_W-1:0] rf_busw_r;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr_r),
        .grant  (arb_grant_s),
        .winner (arb_win_s)
    );

    // Grant selection and next-state logic; ready is held low during reset.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        owner_s = owner_r;
        ready_s = '0;
        win_s   = arb_win_s;
        case (state_r)
            ST_ARB: begin
                win_s = arb_win_s;
                if (rst && !stall) begin
                    ready_s = arb_grant_s;
                end else begin
                    ready_s = '0;
                end
            end
            ST_LOCK: begin
                win_s = owner_r;
                if (rst && !stall && bus.req_valid[owner_r]) begin
                    ready_s[owner_r] = 1'b1;
                end else begin
                    ready_s = '0;
                end
            end
            default: begin
                win_s   = arb_win_s;
                ready_s = '0;
            end
        endcase
        accept_s = |ready_s;
        case (state_r)
            ST_ARB: begin
                if (accept_s) begin
                    ptr_s = (win_s == PTR_W'(NREQ - 1)) ? '0 : win_s + 1'b1;
                    if (bus.req_lock[win_s]) begin
                        state_s = ST_LOCK;
                        owner_s = win_s;
                    end else begin
                        state_s = ST_ARB;
                    end
                end else begin
                    ptr_s = ptr_r;
                end
            end
            ST_LOCK: begin
                // A stalled owner that keeps valid high keeps the lock.
                if (!bus.req_valid[owner_r]) begin
                    state_s = ST_ARB;
                end else if (accept_s && !bus.req_lock[owner_r]) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_LOCK;
                end
            end
            default: state_s = ST_ARB;
        endcase
        win_addr_s = bus.req_addr[int'(win_s)*ADDR_W +: ADDR_W];
        win_data_s = bus.req_data[int'(win_s)*DATA_W +: DATA_W];
    end

    // Arbitration state, round-robin pointer and lock owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_ARB;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            owner_r <= owner_s;
        end
    end

    // Register-file write port; writes to register zero are swallowed here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_r   <= RF_WE_IDLE;
            rf_rw_r   <= '0;
            rf_busw_r <= '0;
        end else if (accept_s) begin
            rf_we_r   <= (win_addr_s == ADDR_W'(REG_ZERO)) ? RF_WE_IDLE : RF_WE_WRITE;
            rf_rw_r   <= win_addr_s;
            rf_busw_r <= win_data_s;
        end else begin
            rf_we_r   <= RF_WE_IDLE;
            rf_rw_r   <= rf_rw_r;
            rf_busw_r <= rf_busw_r;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rf_wE     = rf_we_r;
    assign bus.rf_rW     = rf_rw_r;
    assign bus.rf_busW   = rf_busw_r;

`ifdef RF_WB_PERF_EN
    logic [15:0] cnt_r [NREQ];
    logic [15:0] perf_cnt_s;

    // Saturating grant counters, zero-address beats included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) cnt_r[k] <= 16'd0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (accept_s && (win_s == PTR_W'(k))) begin
                    cnt_r[k] <= sat_inc16(cnt_r[k]);
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        perf_cnt_s = 16'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (perf_sel == 3'(k)) begin
                perf_cnt_s = cnt_r[k];
            end else begin
                perf_cnt_s = perf_cnt_s;
            end
        end
    end

    assign perf_cnt = perf_cnt_s;
`else
    logic unused_perf_sel_s;
    assign unused_perf_sel_s = ^perf_sel;
    assign perf_cnt          = 16'd0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rf_wb_arbiter;
    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  perf_sel = 3'd0;
    logic [15:0] perf_cnt;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .bus      (bus),
        .perf_sel (perf_sel),
        .perf_cnt (perf_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    int          m_cnt [NREQ];
    logic [1:0]  e_we;
    logic [4:0]  e_rw;
    logic [31:0] e_bus;
    logic [2:0]  e_rdy;
    int          e_win;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Expected grant from the arbitration rules.
    task automatic model_pick();
        e_rdy = 3'b000;
        e_win = -1;
        if (rst && !stall) begin
            if (m_locked) begin
                if (bus.req_valid[m_owner]) begin
                    e_rdy[m_owner] = 1'b1;
                    e_win = m_owner;
                end
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (e_win < 0 && bus.req_valid[i]) begin
                        e_win = i;
                        e_rdy[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_edge();
        if (e_win >= 0) begin
            e_rw  = bus.req_addr[e_win*ADDR_W +: ADDR_W];
            e_bus = bus.req_data[e_win*DATA_W +: DATA_W];
            e_we  = (e_rw != 5'd0) ? 2'b01 : 2'b00;
            if (m_cnt[e_win] < 65535) m_cnt[e_win]++;
            if (!m_locked) begin
                m_ptr = (e_win + 1) % NREQ;
                if (bus.req_lock[e_win]) begin
                    m_locked = 1'b1;
                    m_owner  = e_win;
                end
            end else if (!bus.req_lock[m_owner]) begin
                m_locked = 1'b0;
            end
        end else begin
            e_we = 2'b00;
            if (m_locked && !bus.req_valid[m_owner]) m_locked = 1'b0;
        end
    endtask

    // One clock: check ready before the edge, then the registered write port after it.
    task automatic cycle(input string tag);
        #1;
        model_pick();
        check_eq({tag, ".ready"}, 64'(bus.req_ready), 64'(e_rdy));
`ifdef RF_WB_PERF_EN
        check_eq({tag, ".perf"}, 64'(perf_cnt), (int'(perf_sel) < NREQ) ? 64'(m_cnt[perf_sel]) : 64'd0);
`else
        check_eq({tag, ".perf"}, 64'(perf_cnt), 64'd0);
`endif
        @(posedge clk);
        model_edge();
        #1;
        check_eq({tag, ".wE"}, 64'(bus.rf_wE), 64'(e_we));
        check_eq({tag, ".rW"}, 64'(bus.rf_rW), 64'(e_rw));
        check_eq({tag, ".busW"}, 64'(bus.rf_busW), 64'(e_bus));
    endtask

    // Asynchronous reset; returns just after a posedge with inputs idle.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_eq("rst.wE", 64'(bus.rf_wE), 64'd0);
        check_eq("rst.ready", 64'(bus.req_ready), 64'd0);
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        e_we = 2'b00; e_rw = 5'd0; e_bus = 32'd0;
        for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
        @(negedge clk);
        check_eq("rst.rW", 64'(bus.rf_rW), 64'd0);
        check_eq("rst.busW", 64'(bus.rf_busW), 64'd0);
        bus.req_valid = 3'b000;
        bus.req_lock  = 3'b000;
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_g;
        bus.req_valid = 3'b000;
        bus.req_lock  = 3'b000;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // 1: single requester write
        do_reset();
        bus.req_valid = 3'b001;
        set_req(0, 5'd9, 32'd5);
        #1;
        check_eq("t1.ready", 64'(bus.req_ready), 64'h1);
        cycle("t1");
        check_eq("t1.wE_c", 64'(bus.rf_wE), 64'h1);
        check_eq("t1.rW_c", 64'(bus.rf_rW), 64'd9);
        check_eq("t1.busW_c", 64'(bus.rf_busW), 64'd5);
        bus.req_valid = 3'b000;

        // 2: round robin with all requesters valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'(100 + i));
        bus.req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_g = 3'b001 << (k % 3);
            #1;
            check_eq("t2.rr", 64'(bus.req_ready), 64'(exp_g));
            cycle("t2");
        end

        // 3: locked burst from requester 0 holds off requester 1
        do_reset();
        bus.req_valid = 3'b011;
        bus.req_lock  = 3'b001;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.req_lock = 3'b000;
            exp_g = (k < 3) ? 3'b001 : 3'b010;
            #1;
            check_eq("t3.lock", 64'(bus.req_ready), 64'(exp_g));
            cycle("t3");
        end

        // 4: write to register zero is consumed but not written
        do_reset();
        bus.req_valid = 3'b001;
        set_req(0, 5'd0, 32'hAA);
        #1;
        check_eq("t4.ready", 64'(bus.req_ready), 64'h1);
        cycle("t4");
        check_eq("t4.wE_c", 64'(bus.rf_wE), 64'h0);

        // 5: stall during lock keeps the owner
        do_reset();
        set_req(1, 5'd3, 32'h33);
        bus.req_valid = 3'b010;
        bus.req_lock  = 3'b010;
        cycle("t5a");
        bus.req_valid = 3'b111;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq("t5.stall_ready", 64'(bus.req_ready), 64'h0);
            cycle("t5s");
            check_eq("t5.stall_wE", 64'(bus.rf_wE), 64'h0);
        end
        stall = 1'b0;
        bus.req_lock = 3'b000;
        #1;
        check_eq("t5.kept", 64'(bus.req_ready), 64'h2);
        cycle("t5b");

        // Reset mid-lock, then arbitration restarts from requester 0
        bus.req_valid = 3'b001;
        bus.req_lock  = 3'b001;
        set_req(0, 5'd7, 32'h77);
        cycle("t5c");
        check_eq("t5.pre_wE", 64'(bus.rf_wE), 64'h1);
        do_reset();
        bus.req_valid = 3'b111;
        #1;
        check_eq("t5.arb", 64'(bus.req_ready), 64'h1);
        cycle("t5d");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.req_valid = 3'($urandom_range(0, 7));
            bus.req_lock  = 3'($urandom_range(0, 7));
            stall = ($urandom_range(0, 5) == 0);
            perf_sel = 3'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
            end
            cycle("rnd");
        end

`ifdef RF_WB_PERF_EN
        // 6: counter saturation on requester 2
        bus.req_valid = 3'b100;
        bus.req_lock  = 3'b000;
        stall = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        perf_sel = 3'd2;
        #1;
        check_eq("t6.sat", 64'(perf_cnt), 64'hFFFF);
        perf_sel = 3'd5;
        #1;
        check_eq("t6.oob", 64'(perf_cnt), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
